// File: rtl/spi_slave_sync.sv
// SPI slave for a fast system clock: the SPI pins are synchronised and edge-detected,
// so all state runs on clk. Full-duplex, MSB first, with a one-word TX holding register.
module spi_slave_sync #(
    parameter int                DATA_W    = 8,
    parameter int                CPOL      = 0,
    parameter int                CPHA      = 0,
    parameter logic [DATA_W-1:0] IDLE_FILL = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              underrun
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 32'sd1);
    localparam logic             SCK_IDLE = (CPOL != 32'sd0);
    localparam logic             PHASE1   = (CPHA != 32'sd0);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              sck_meta_r, sck_sync_r, sck_dly_r;
    logic              cs_meta_r, cs_sync_r, cs_dly_r;
    logic              mosi_meta_r, mosi_sync_r;
    logic              post_rst_r, armed_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] rx_shift_r, rx_data_r, tx_shift_r, hold_r;
    logic              rx_valid_r, tx_ready_r, underrun_r, miso_r;

    logic              lead_s, trail_s, sample_s, shift_s;
    logic              cs_fall_s, cs_rise_s, active_s, start_s;
    logic              word_done_s, reload_s;
    logic [DATA_W-1:0] next_word_s;

    // Edge and event decode from the synchronised bus
    always_comb begin
        lead_s  = 1'b0;
        trail_s = 1'b0;
        if (SCK_IDLE) begin
            lead_s  = ~sck_sync_r & sck_dly_r;
            trail_s = sck_sync_r & ~sck_dly_r;
        end else begin
            lead_s  = sck_sync_r & ~sck_dly_r;
            trail_s = ~sck_sync_r & sck_dly_r;
        end
        if (PHASE1) begin
            sample_s = trail_s;
            shift_s  = lead_s;
        end else begin
            sample_s = lead_s;
            shift_s  = trail_s;
        end
    end

    assign cs_fall_s   = ~cs_sync_r & cs_dly_r;
    assign cs_rise_s   = cs_sync_r & ~cs_dly_r;
    assign active_s    = (state_r == ST_ACTIVE);
    // A fall only counts once cs has been seen high after reset (no restart mid-frame).
    assign start_s     = (state_r == ST_IDLE) && cs_fall_s && armed_r;
    assign word_done_s = active_s && sample_s && (bit_cnt_r == {CNT_W{1'b0}});
    assign reload_s    = start_s || (word_done_s && !cs_rise_s);
    assign next_word_s = tx_ready_r ? IDLE_FILL : hold_r;

    // Two-flop synchronisers plus delayed copies for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_meta_r  <= SCK_IDLE;
            sck_sync_r  <= SCK_IDLE;
            sck_dly_r   <= SCK_IDLE;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_dly_r    <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            post_rst_r  <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            sck_meta_r  <= sck;
            sck_sync_r  <= sck_meta_r;
            sck_dly_r   <= sck_sync_r;
            cs_meta_r   <= cs;
            cs_sync_r   <= cs_meta_r;
            cs_dly_r    <= cs_sync_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
            post_rst_r  <= 1'b1;
            armed_r     <= armed_r | (post_rst_r & cs_meta_r);
        end
    end

    // Transaction state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Receive shifter, bit counter and completed-word output
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r  <= LAST_BIT;
            rx_shift_r <= {DATA_W{1'b0}};
            rx_data_r  <= {DATA_W{1'b0}};
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= word_done_s;
            if (word_done_s) begin
                rx_data_r <= {rx_shift_r[DATA_W-2:0], mosi_sync_r};
            end
            if (!active_s || cs_rise_s) begin
                bit_cnt_r  <= LAST_BIT;
                rx_shift_r <= {DATA_W{1'b0}};
            end else if (sample_s) begin
                rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_sync_r};
                bit_cnt_r  <= (bit_cnt_r == {CNT_W{1'b0}}) ? LAST_BIT : bit_cnt_r - 1'b1;
            end
        end
    end

    // TX holding register, underrun flag, transmit shifter and miso
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r     <= {DATA_W{1'b0}};
            tx_ready_r <= 1'b1;
            underrun_r <= 1'b0;
            tx_shift_r <= {DATA_W{1'b0}};
            miso_r     <= 1'b0;
        end else begin
            if (tx_valid && tx_ready_r) begin
                hold_r     <= tx_data;
                tx_ready_r <= 1'b0;
            end else if (reload_s) begin
                tx_ready_r <= 1'b1;
            end
            if (reload_s && tx_ready_r) begin
                underrun_r <= 1'b1;
            end
            // CPHA=0 presents the MSB at cs fall; CPHA=1 waits for the first leading edge.
            if (start_s) begin
                if (PHASE1) begin
                    tx_shift_r <= next_word_s;
                    miso_r     <= 1'b0;
                end else begin
                    tx_shift_r <= {next_word_s[DATA_W-2:0], 1'b0};
                    miso_r     <= next_word_s[DATA_W-1];
                end
            end else if (!active_s || cs_rise_s) begin
                miso_r <= 1'b0;
            end else if (word_done_s) begin
                tx_shift_r <= next_word_s;
            end else if (shift_s) begin
                miso_r     <= tx_shift_r[DATA_W-1];
                tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign miso     = miso_r;
    assign tx_ready = tx_ready_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign busy     = (state_r == ST_ACTIVE);
    assign underrun = underrun_r;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: four 8-bit builds (all CPOL/CPHA) plus a 16-bit mode-0 build,
// driven by a bit-level SPI master and compared with a word-level queue model.
module tb_spi_slave_sync;

    localparam int H = 6;  // clk cycles per sck half period

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] sck_v, cs_v, mosi_v, tx_valid_v;
    wire  [4:0] miso_v, tx_ready_v, rx_valid_v, busy_v, und_v;
    logic [7:0] tx8 [4];
    logic [7:0] rx8 [4];
    logic [15:0] tx16, rx16;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_sync #(.DATA_W(8), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
            .clk(clk), .rst(rst), .sck(sck_v[g]), .cs(cs_v[g]), .mosi(mosi_v[g]),
            .miso(miso_v[g]), .tx_data(tx8[g]), .tx_valid(tx_valid_v[g]),
            .tx_ready(tx_ready_v[g]), .rx_data(rx8[g]), .rx_valid(rx_valid_v[g]),
            .busy(busy_v[g]), .underrun(und_v[g]));
    end

    spi_slave_sync #(.DATA_W(16), .CPOL(0), .CPHA(0)) u_dut16 (
        .clk(clk), .rst(rst), .sck(sck_v[4]), .cs(cs_v[4]), .mosi(mosi_v[4]),
        .miso(miso_v[4]), .tx_data(tx16), .tx_valid(tx_valid_v[4]),
        .tx_ready(tx_ready_v[4]), .rx_data(rx16), .rx_valid(rx_valid_v[4]),
        .busy(busy_v[4]), .underrun(und_v[4]));

    // Model state: words offered to each slave, how many the slave should have consumed,
    // words the slave reported on rx_valid, and the expected sticky underrun flag.
    logic [31:0] feed_mem [5][64];
    int          feed_wr [5];
    int          feed_rd [5];
    logic        feed_pend [5];
    int          mod_rd [5];
    logic        und_exp [5];
    logic [31:0] rx_mem [5][64];
    int          rx_wr [5];
    int          rx_rd [5];
    logic [31:0] send_w [4];
    logic [31:0] recv_w [4];
    logic [31:0] exp_w [5];
    int          total = 0;
    int          bad = 0;

    function automatic int dw(input int m);
        return (m == 4) ? 16 : 8;
    endfunction

    function automatic logic [31:0] mask(input int m);
        return (m == 4) ? 32'h0000_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [31:0] rx_of(input int m);
        return (m == 4) ? {16'h0, rx16} : {24'h0, rx8[m]};
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int m, input logic [31:0] w);
        feed_mem[m][feed_wr[m] % 64] = w & mask(m);
        feed_wr[m]++;
    endtask

    // Each load (cs fall, or word completion) takes the next offered word, else the fill word.
    function automatic logic [31:0] model_load(input int m);
        logic [31:0] w;
        if (mod_rd[m] < feed_wr[m]) begin
            w = feed_mem[m][mod_rd[m] % 64];
            mod_rd[m]++;
        end else begin
            w = 32'h0000_00A5;
            und_exp[m] = 1'b1;
        end
        return w;
    endfunction

    // Producer: keeps tx_valid asserted while offered words remain, one handshake at a time.
    initial begin
        tx_valid_v = 5'b0;
        for (int m = 0; m < 4; m++) tx8[m] = 8'h0;
        tx16 = 16'h0;
        for (int m = 0; m < 5; m++) begin
            feed_rd[m] = 0;
            feed_pend[m] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int m = 0; m < 5; m++) begin
                if (feed_pend[m]) feed_rd[m]++;
                if (feed_rd[m] < feed_wr[m]) begin
                    tx_valid_v[m] = 1'b1;
                    if (m == 4) tx16 = feed_mem[m][feed_rd[m] % 64][15:0];
                    else        tx8[m] = feed_mem[m][feed_rd[m] % 64][7:0];
                end else begin
                    tx_valid_v[m] = 1'b0;
                end
                feed_pend[m] = tx_valid_v[m] && tx_ready_v[m];
            end
        end
    end

    // Receive monitor: records every word announced by rx_valid
    always @(negedge clk) begin
        for (int m = 0; m < 5; m++) begin
            if (rx_valid_v[m]) begin
                rx_mem[m][rx_wr[m] % 64] <= rx_of(m);
                rx_wr[m] <= rx_wr[m] + 1;
            end
        end
    end

    // Bit-level SPI master; cut>0 stops after that many bits, keep_low leaves cs asserted.
    task automatic spi_xfer(input int m, input int nw, input int cut, input bit keep_low);
        int nb;
        int cnt;
        logic cp, ph;
        logic [31:0] r;
        nb  = dw(m);
        cp  = (m < 4) ? ((m / 2) != 0) : 1'b0;
        ph  = (m < 4) ? ((m % 2) != 0) : 1'b0;
        cnt = 0;
        sck_v[m] = cp;
        cs_v[m]  = 1'b0;
        if (!ph) mosi_v[m] = send_w[0][nb-1];
        clks(H);
        chk($sformatf("m%0d_busy_active", m), {31'h0, busy_v[m]}, 32'h1);
        for (int k = 0; k < nw; k++) begin
            r = 32'h0;
            for (int b = nb - 1; b >= 0 && (cut == 0 || cnt < cut); b--) begin
                if (!ph) begin
                    mosi_v[m] = send_w[k][b];
                    clks(H);
                    r = {r[30:0], miso_v[m]};
                    sck_v[m] = ~cp;
                    clks(H);
                    sck_v[m] = cp;
                end else begin
                    sck_v[m]  = ~cp;
                    mosi_v[m] = send_w[k][b];
                    clks(H);
                    r = {r[30:0], miso_v[m]};
                    sck_v[m] = cp;
                    clks(H);
                end
                cnt++;
            end
            recv_w[k] = r;
        end
        if (!keep_low) begin
            clks(H);
            cs_v[m] = 1'b1;
            clks(2 * H);
        end
    endtask

    // Complete transfer of nw words checked against the model
    task automatic run_full(input int m, input int nw);
        for (int k = 0; k <= nw; k++) exp_w[k] = model_load(m);
        spi_xfer(m, nw, 0, 1'b0);
        chk($sformatf("m%0d_rx_count", m), rx_wr[m] - rx_rd[m], nw);
        for (int k = 0; k < nw; k++) begin
            chk($sformatf("m%0d_miso_w%0d", m, k), recv_w[k], exp_w[k] & mask(m));
            chk($sformatf("m%0d_rx_w%0d", m, k), rx_mem[m][(rx_rd[m] + k) % 64], send_w[k] & mask(m));
        end
        rx_rd[m] = rx_wr[m];
        chk($sformatf("m%0d_underrun", m), {31'h0, und_v[m]}, {31'h0, und_exp[m]});
        chk($sformatf("m%0d_busy_idle", m), {31'h0, busy_v[m]}, 32'h0);
        chk($sformatf("m%0d_miso_idle", m), {31'h0, miso_v[m]}, 32'h0);
    endtask

    task automatic chk_reset(input int m);
        chk($sformatf("m%0d_rst_miso", m), {31'h0, miso_v[m]}, 32'h0);
        chk($sformatf("m%0d_rst_rx_data", m), rx_of(m), 32'h0);
        chk($sformatf("m%0d_rst_rx_valid", m), {31'h0, rx_valid_v[m]}, 32'h0);
        chk($sformatf("m%0d_rst_tx_ready", m), {31'h0, tx_ready_v[m]}, 32'h1);
        chk($sformatf("m%0d_rst_busy", m), {31'h0, busy_v[m]}, 32'h0);
        chk($sformatf("m%0d_rst_underrun", m), {31'h0, und_v[m]}, 32'h0);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 5; m++) begin
            und_exp[m] = 1'b0;
            mod_rd[m]  = feed_wr[m];
            rx_rd[m]   = rx_wr[m];
        end
    endtask

    initial begin
        int m, nw, q;
        for (int i = 0; i < 5; i++) begin
            feed_wr[i] = 0;
            mod_rd[i]  = 0;
            rx_rd[i]   = 0;
            und_exp[i] = 1'b0;
        end
        rst    = 1'b1;
        sck_v  = 5'b01100;
        cs_v   = 5'b11111;
        mosi_v = 5'b00000;
        clks(3);
        rst = 1'b0;
        clks(4);
        for (int i = 0; i < 5; i++) chk_reset(i);

        // Mode 0: 3C queued (plus a follow-on word), master sends C3
        push(0, 32'h3C);
        push(0, 32'h5B);
        clks(4);
        send_w[0] = 32'hC3;
        run_full(0, 1);

        // Nothing queued: fill word goes out and underrun latches
        clks(4);
        send_w[0] = $urandom & 32'hFF;
        run_full(1, 1);

        // Every CPOL/CPHA build: 96 in, 5A out
        for (int i = 0; i < 4; i++) begin
            push(i, 32'h5A);
            push(i, $urandom);
            clks(4);
            send_w[0] = 32'h96;
            run_full(i, 1);
        end

        // Random multi-word frames with random queue depth (including underruns)
        repeat (8) begin
            m  = $urandom_range(0, 3);
            nw = $urandom_range(1, 3);
            q  = $urandom_range(0, nw + 1);
            for (int i = 0; i < q; i++) push(m, $urandom);
            clks(4);
            for (int k = 0; k < nw; k++) send_w[k] = $urandom & 32'hFF;
            run_full(m, nw);
        end

        // 16-bit back-to-back words inside one cs window
        push(4, 32'h0F0F);
        push(4, 32'hF0F0);
        push(4, $urandom);
        clks(4);
        send_w[0] = 32'h1234;
        send_w[1] = 32'hABCD;
        run_full(4, 2);

        // cs raised after 5 bits, then a full 81 transfer
        for (int i = 0; i < 3; i++) push(0, $urandom);
        clks(4);
        send_w[0] = $urandom & 32'hFF;
        exp_w[0] = model_load(0);
        spi_xfer(0, 1, 5, 1'b0);
        chk("partial_no_rx_valid", rx_wr[0] - rx_rd[0], 0);
        chk("partial_busy_idle", {31'h0, busy_v[0]}, 32'h0);
        send_w[0] = 32'h81;
        run_full(0, 1);

        // Reset after 4 bits with cs held low; slave must wait for a fresh cs fall
        clks(4);
        send_w[0] = $urandom & 32'hFF;
        spi_xfer(0, 1, 4, 1'b1);
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) chk_reset(i);
        clks(3 * H);
        chk("rst_cs_low_stays_idle", {31'h0, busy_v[0]}, 32'h0);
        chk("rst_cs_low_no_rx", rx_wr[0] - rx_rd[0], 0);
        cs_v[0] = 1'b1;
        clks(2 * H);
        push(0, $urandom);
        clks(4);
        send_w[0] = 32'h7E;
        run_full(0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
